time_unit_counter: RTL and testbench

//   Generic modulo-N clock digit pair (seconds, minutes, hours) for the digital clock.

---
 rtl/time_unit_counter.sv | 148 ++++++++++++++
 tb/tb_time_unit_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_unit_counter.sv
// time_unit_counter: one modulo-MODULO clock digit pair (sec/min/hr) with auto advance, button step, load and BCD split.
// Latency: load/advance land on the next clk50 edge; a button step lands 3 edges after btn_n falls; tens/ones are combinational.
// Backpressure: none; hold freezes only the automatic advance, and lower-priority events in a busy cycle are dropped. `BLINK_EN adds edit-mode blink.
module time_unit_counter #(
  parameter int MODULO   = 60,
  parameter int WIDTH    = 7,
  parameter int PRESCALE = 50000000,
  parameter int EXT_TICK = 0
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             hold,
  input  logic             tick_in,
  input  logic             btn_n,
  input  logic             dir_up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             blank
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  // One extra bit so a MODULO equal to 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic             btn_s1;
  logic             btn_s2;
  logic             btn_d;
  logic             step;
  logic             adv;
  logic [WIDTH-1:0] count_nxt;
  logic             carry_nxt;
  logic [7:0]       cnt8;

  // Two-flop synchroniser plus edge register for the asynchronous push-button.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      btn_d  <= 1'b1;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  // Only the press (1->0) produces a step; holding or releasing does nothing.
  assign step = btn_d & ~btn_s2;

  generate
    if (EXT_TICK != 0) begin : g_ext
      // Cascaded stage: advance on the lower stage's carry unless being edited.
      assign adv = tick_in & ~hold;
    end else begin : g_pre
      logic [PW-1:0] pre_cnt;
      logic          pre_last;
      logic          unused_tick;

      assign unused_tick = tick_in;
      assign pre_last    = (pre_cnt == PW'(PRESCALE - 1));
      assign adv         = pre_last & ~hold;

      // Free-running tick prescaler; hold freezes the phase rather than clearing it.
      always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
          pre_cnt <= '0;
        end else if (!hold) begin
          pre_cnt <= pre_last ? '0 : pre_cnt + 1'b1;
        end
      end
    end
  endgenerate

  // Next count with load > step > advance; only an automatic wrap raises carry.
  always_comb begin
    count_nxt = count;
    carry_nxt = 1'b0;
    if (load) begin
      count_nxt = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    end else if (step) begin
      if (dir_up) begin
        count_nxt = (count == MAX_VAL) ? '0 : count + 1'b1;
      end else begin
        count_nxt = (count == '0) ? MAX_VAL : count - 1'b1;
      end
    end else if (adv) begin
      if (count == MAX_VAL) begin
        count_nxt = '0;
        carry_nxt = 1'b1;
      end else begin
        count_nxt = count + 1'b1;
      end
    end
  end

  // Count and carry registers; carry is high exactly while count first shows 0 after a wrap.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      carry_out <= 1'b0;
    end else begin
      count     <= count_nxt;
      carry_out <= carry_nxt;
    end
  end

  // Count never exceeds 99, so an 8-bit view is enough for the BCD split.
  assign cnt8 = 8'(count);
  assign tens = 4'(cnt8 / 8'd10);
  assign ones = 4'(cnt8 % 8'd10);

`ifdef BLINK_EN
  localparam int BH = (PRESCALE / 2 > 1) ? PRESCALE / 2 : 1;
  localparam int BW = (BH > 1) ? $clog2(BH) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink;

  // Edit-mode blink: toggle every half tick period while held, clear as soon as hold drops.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (hold) begin
      if (blink_cnt == BW'(BH - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end
  end

  // blink can only be set while hold was high, so it already equals blink & hold registered.
  assign blank = blink;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_time_unit_counter.sv
// Bench for time_unit_counter: a seconds stage on the internal prescaler cascaded into a minutes stage.
// A behavioural model predicts every output each cycle; directed literal checks pin the model.
// Randomised stimulus exercises load/step/hold interaction on both stages.
module tb_time_unit_counter;

  localparam int MODULO   = 60;
  localparam int WIDTH    = 7;
  localparam int PRESCALE = 4;
`ifdef BLINK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif

  logic             clk50 = 1'b0;
  logic             reset;
  logic             hold, btn_n, dir_up, load, s_tick;
  logic [WIDTH-1:0] load_val;
  logic             m_hold, m_btn_n, m_dir_up, m_load;
  logic [WIDTH-1:0] m_load_val;
  logic [WIDTH-1:0] s_count, m_count;
  logic             s_carry, m_carry, s_blank, m_blank;
  logic [3:0]       s_tens, s_ones, m_tens, m_ones;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk50 = ~clk50;

  time_unit_counter #(.MODULO(MODULO), .WIDTH(WIDTH), .PRESCALE(PRESCALE), .EXT_TICK(0)) u_sec (
    .clk50(clk50), .reset(reset), .hold(hold), .tick_in(s_tick), .btn_n(btn_n),
    .dir_up(dir_up), .load(load), .load_val(load_val), .count(s_count),
    .carry_out(s_carry), .tens(s_tens), .ones(s_ones), .blank(s_blank)
  );

  time_unit_counter #(.MODULO(MODULO), .WIDTH(WIDTH), .PRESCALE(PRESCALE), .EXT_TICK(1)) u_min (
    .clk50(clk50), .reset(reset), .hold(m_hold), .tick_in(s_carry), .btn_n(m_btn_n),
    .dir_up(m_dir_up), .load(m_load), .load_val(m_load_val), .count(m_count),
    .carry_out(m_carry), .tens(m_tens), .ones(m_ones), .blank(m_blank)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk50);
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 = seconds stage, 1 = minutes stage.
  int mc[2];            // expected count
  int mcar[2];          // expected carry_out
  int mbl[2];           // expected blank
  int mbc[2];           // cycles spent held since last blink toggle
  int bh1[2], bh2[2], bh3[2];  // btn_n seen at the previous 1, 2, 3 edges
  int run_cycles;       // edges the seconds stage has spent un-held since reset
  int e_adv[2], e_ld[2], e_hd[2], e_bt[2], e_du[2], e_lv[2], e_step;

  always @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        mc[s] = 0; mcar[s] = 0; mbl[s] = 0; mbc[s] = 0;
        bh1[s] = 1; bh2[s] = 1; bh3[s] = 1;
      end
      run_cycles = 0;
    end else begin
      e_ld[0] = int'(load);   e_hd[0] = int'(hold);   e_bt[0] = int'(btn_n);
      e_du[0] = int'(dir_up); e_lv[0] = int'(load_val);
      e_ld[1] = int'(m_load);   e_hd[1] = int'(m_hold);   e_bt[1] = int'(m_btn_n);
      e_du[1] = int'(m_dir_up); e_lv[1] = int'(m_load_val);
      // Every PRESCALE-th un-held edge is a tick; the minute stage ticks on the seconds carry.
      e_adv[0] = (e_hd[0] == 0 && (run_cycles % PRESCALE) == PRESCALE - 1) ? 1 : 0;
      e_adv[1] = (mcar[0] == 1 && e_hd[1] == 0) ? 1 : 0;
      if (e_hd[0] == 0) run_cycles++;
      for (int s = 0; s < 2; s++) begin
        // A press seen three edges back, still low two edges back, steps now.
        e_step = (bh3[s] == 1 && bh2[s] == 0) ? 1 : 0;
        bh3[s] = bh2[s]; bh2[s] = bh1[s]; bh1[s] = e_bt[s];
        if (e_ld[s] != 0) begin
          mc[s] = (e_lv[s] >= MODULO) ? MODULO - 1 : e_lv[s];
          mcar[s] = 0;
        end else if (e_step != 0) begin
          mc[s] = (e_du[s] != 0) ? (mc[s] + 1) % MODULO : (mc[s] + MODULO - 1) % MODULO;
          mcar[s] = 0;
        end else if (e_adv[s] != 0) begin
          mcar[s] = (mc[s] == MODULO - 1) ? 1 : 0;
          mc[s] = (mc[s] + 1) % MODULO;
        end else begin
          mcar[s] = 0;
        end
`ifdef BLINK_EN
        if (e_hd[s] != 0) begin
          mbc[s]++;
          if (mbc[s] == ((PRESCALE / 2 > 1) ? PRESCALE / 2 : 1)) begin
            mbl[s] = 1 - mbl[s];
            mbc[s] = 0;
          end
        end else begin
          mbl[s] = 0; mbc[s] = 0;
        end
`endif
      end
    end
  end

  // Per-cycle comparison of both stages against the model.
  always @(negedge clk50) begin
    if (reset) begin
      chk("sec_count", int'(s_count), mc[0]);
      chk("sec_carry", int'(s_carry), mcar[0]);
      chk("sec_tens",  int'(s_tens),  mc[0] / 10);
      chk("sec_ones",  int'(s_ones),  mc[0] % 10);
      chk("sec_blank", int'(s_blank), mbl[0]);
      chk("min_count", int'(m_count), mc[1]);
      chk("min_carry", int'(m_carry), mcar[1]);
      chk("min_tens",  int'(m_tens),  mc[1] / 10);
      chk("min_ones",  int'(m_ones),  mc[1] % 10);
      chk("min_blank", int'(m_blank), mbl[1]);
    end
  end

  int seen;

  initial begin
    reset = 1'b0; hold = 1'b0; btn_n = 1'b1; dir_up = 1'b1; load = 1'b0; load_val = '0; s_tick = 1'b0;
    m_hold = 1'b0; m_btn_n = 1'b1; m_dir_up = 1'b1; m_load = 1'b0; m_load_val = '0;
    cyc(3);
    chk("reset_count", int'(s_count), 0);
    chk("reset_carry", int'(s_carry), 0);
    chk("reset_blank", int'(s_blank), 0);
    reset = 1'b1;                                   // N0: prescaler starts at 0
    // Free run from 58 through a wrap; load on a tick edge also drops that tick.
    cyc(3); load = 1'b1; load_val = 7'd58;          // N3
    cyc(1); load = 1'b0;
    chk("load_58", int'(s_count), 58);              // N4
    cyc(4);
    chk("run_59", int'(s_count), 59);               // N8
    chk("run_59_carry", int'(s_carry), 0);
    chk("tens_5", int'(s_tens), 5);
    chk("ones_9", int'(s_ones), 9);
    cyc(4);
    chk("wrap_count", int'(s_count), 0);            // N12
    chk("wrap_carry", int'(s_carry), 1);
    cyc(1);
    chk("carry_one_cycle", int'(s_carry), 0);       // N13
    chk("min_took_carry", int'(m_count), 1);
    cyc(3);
    chk("after_wrap_1", int'(s_count), 1);          // N16
    chk("after_wrap_carry", int'(s_carry), 0);
    // Edit mode: step down from 0 wraps to 59, no carry, prescaler phase kept.
    hold = 1'b1; load = 1'b1; load_val = 7'd0;
    cyc(1); load = 1'b0; btn_n = 1'b0; dir_up = 1'b0;   // N17
    cyc(1); btn_n = 1'b1;                               // N18
    cyc(1);
    chk("step_not_yet", int'(s_count), 0);          // N19
    cyc(1);
    chk("step_down_wrap", int'(s_count), 59);       // N20
    chk("step_no_carry", int'(s_carry), 0);
    hold = 1'b0;
    cyc(3);
    chk("phase_kept", int'(s_count), 59);           // N23
    cyc(1);
    chk("phase_tick", int'(s_count), 0);            // N24
    chk("phase_tick_carry", int'(s_carry), 1);
    // Load 75 collides with a step and a tick: clamp to 59, others dropped.
    cyc(1); btn_n = 1'b0; dir_up = 1'b1;            // N25
    cyc(2); load = 1'b1; load_val = 7'd75;          // N27
    cyc(1); load = 1'b0; btn_n = 1'b1;              // N28
    chk("load_clamp", int'(s_count), 59);
    chk("load_clamp_carry", int'(s_carry), 0);
    cyc(3);
    chk("not_deferred", int'(s_count), 59);         // N31
    cyc(1);
    chk("next_tick_wrap", int'(s_count), 0);        // N32
    chk("next_tick_carry", int'(s_carry), 1);
    // Blink pattern while held.
    hold = 1'b1;
    cyc(1); chk("blank_33", int'(s_blank), 0);
    cyc(1); chk("blank_34", int'(s_blank), BL);
    cyc(1); chk("blank_35", int'(s_blank), BL);
    cyc(1); chk("blank_36", int'(s_blank), 0);
    cyc(2); chk("blank_38", int'(s_blank), BL);
    chk("held_count", int'(s_count), 0);
    hold = 1'b0;
    cyc(1); chk("blank_release", int'(s_blank), 0);

    // Randomised phase.
    repeat (2000) begin
      @(negedge clk50);
      if ($urandom_range(0, 7) == 0) hold = ~hold;
      if ($urandom_range(0, 5) == 0) btn_n = ~btn_n;
      dir_up   = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 15) == 0);
      load_val = 7'($urandom_range(0, 127));
      s_tick   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) m_hold = ~m_hold;
      if ($urandom_range(0, 7) == 0) m_btn_n = ~m_btn_n;
      m_dir_up   = 1'($urandom_range(0, 1));
      m_load     = ($urandom_range(0, 39) == 0);
      m_load_val = 7'($urandom_range(0, 127));
    end
    hold = 1'b0; btn_n = 1'b1; load = 1'b0; s_tick = 1'b0;
    m_hold = 1'b0; m_btn_n = 1'b1; m_load = 1'b0;
    cyc(4);

    // Cascade: 120 seconds give two minutes and no minute carry.
    load = 1'b1; load_val = 7'd0; m_load = 1'b1; m_load_val = 7'd0;
    cyc(1); load = 1'b0; m_load = 1'b0;
    seen = 0;
    repeat (484) begin
      cyc(1);
      if (m_carry) seen = 1;
    end
    chk("cascade_min", int'(m_count), 2);
    chk("cascade_min_carry", seen, 0);

    // Asynchronous reset mid-count at 37.
    hold = 1'b1; load = 1'b1; load_val = 7'd37;
    cyc(1); load = 1'b0;
    chk("pre_reset_37", int'(s_count), 37);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_count", int'(s_count), 0);
    chk("async_reset_carry", int'(s_carry), 0);
    chk("async_reset_min", int'(m_count), 0);
    @(negedge clk50);
    reset = 1'b1; hold = 1'b0;
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
